pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Controls the fetch-stage program counter of the five-stage pipeline.
- Each cycle it decides whether the PC advances, holds, or redirects, and drives IF/ID write/flush and ID/EX bubble controls to match.
- Inputs: load-use hazards, ID-stage branch/jump redirects, and instruction/data memory wait states.
- Holds a redirect that arrives during a memory wait until it can be applied, so no redirect is lost.

Parameters:
- WAIT_LIMIT, 15: consecutive memory-wait cycles after which WaitTimeout asserts.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCPlus4  in  32  sequential next address (current PC + 4).
- BranchTarget  in  32  redirect target from ID.
- Redirect  in  1  branch taken or jump resolved in ID.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  load destination register.
- IFID_Rs  in  5  ID source register.
- IFID_Rt  in  5  ID source register.
- IMemReady  in  1  instruction memory ready.
- DMemReady  in  1  data memory ready.
- NextAddress  out  32  address presented to the PC register.
- PCWrite  out  1  1 = PC loads NextAddress.
- IFIDWrite  out  1  1 = IF/ID captures.
- IFIDFlush  out  1  1 = IF/ID cleared to NOP.
- IDEXBubble  out  1  1 = ID/EX control zeroed.
- WaitTimeout  out  1  sticky timeout flag.

Behaviour:
- Registered state is {RUN, MEMWAIT, REDIRPEND}, plus RedirHold[31:0] and WaitCnt. Outputs are Mealy: a function of state and current inputs, with zero-cycle response.
- Reset (Reset=0, asynchronous):
  - state=RUN, WaitCnt=0, RedirHold=0, WaitTimeout=0.
  - Outputs while in reset: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, NextAddress=0.
- LoadUse = IDEX_MemRead & (IDEX_Rt!=0) & (IDEX_Rt==IFID_Rs | IDEX_Rt==IFID_Rt).
- MemBusy = ~IMemReady | ~DMemReady.
- Priority, highest first: MemBusy > LoadUse > Redirect > normal.
- RUN state:
  - MemBusy: PCWrite=0, IFIDWrite=0, IDEXBubble=0, IFIDFlush=0 (whole pipe frozen).
    - If Redirect & ~LoadUse: RedirHold<=BranchTarget, go REDIRPEND.
    - Otherwise go MEMWAIT.
    - WaitCnt<=1.
  - LoadUse: PCWrite=0, IFIDWrite=0, IDEXBubble=1. Redirect is ignored this cycle because branch operands are not yet valid.
  - Redirect: NextAddress=BranchTarget, PCWrite=1, IFIDWrite=1, IFIDFlush=1.
  - Otherwise: NextAddress=PCPlus4, PCWrite=1, IFIDWrite=1, all other controls 0.
- MEMWAIT state:
  - Frozen as above while MemBusy; WaitCnt increments and saturates at WAIT_LIMIT.
  - When ~MemBusy, return to RUN in the same cycle; outputs are evaluated with RUN rules that cycle; WaitCnt<=0.
  - A Redirect seen in MEMWAIT with ~LoadUse latches RedirHold and moves to REDIRPEND.
- REDIRPEND state:
  - Frozen while MemBusy; the Redirect input is ignored because the pending redirect wins.
  - On the first ~MemBusy cycle: NextAddress=RedirHold, PCWrite=1, IFIDWrite=1, IFIDFlush=1, then go RUN.
- Timeout:
  - WaitTimeout sets when WaitCnt reaches WAIT_LIMIT.
  - It stays set until reset and does not alter sequencing.
- NextAddress outside a redirect is always PCPlus4, even when PCWrite=0.

Optional Feature:
- Macro PC_SEQ_STATS_EN adds StallCycles[31:0] and FlushCount[31:0] outputs.
- StallCycles increments on every cycle with PCWrite=0 while out of reset.
- FlushCount increments on every cycle with IFIDFlush=1 while out of reset.
- Both counters wrap at 2^32 and clear on reset.
- Without the macro, both ports exist and are tied to 0.

Decomposition:
- Package pc_seq_pkg contains:
  - state encoding (RUN=2'd0, MEMWAIT=2'd1, REDIRPEND=2'd2);
  - RESET_VECTOR=32'h00000000;
  - REG_ZERO=5'd0.
- Sub-module load_use_detect is purely combinational and produces LoadUse from the IDEX/IFID fields.

Test Plan:
- Reset release, all ready, PCPlus4=0x4 → NextAddress=0x4, PCWrite=1; during reset IFIDFlush=1 and PCWrite=0.
- IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 → one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1. With IDEX_Rt=0 → no stall.
- Redirect=1, BranchTarget=0x40 → NextAddress=0x40, PCWrite=1, IFIDFlush=1 in the same cycle.
- DMemReady=0 for 3 cycles while Redirect=1, target 0x80, pulsed in the first cycle → frozen for 3 cycles. On the ready cycle: NextAddress=0x80, IFIDFlush=1, then back in RUN.
- LoadUse and Redirect together → stall only, no flush. Next cycle with Redirect=1 → redirect taken.
- IMemReady=0 for 16 cycles → WaitTimeout=1 on cycle 15 and stays 1 after ready returns; only Reset=0 clears it.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEMWAIT   = 2'd1,
        REDIRPEND = 2'd2
    } seq_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO     = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the EX load and the ID source registers.
module load_use_detect
    import pc_seq_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // A load into r0 never produces a real dependency.
    assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: advance/hold/redirect decision plus IF/ID and ID/EX controls.
// Optional macro PC_SEQ_STATS_EN enables the StallCycles/FlushCount counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] BranchTarget,
    input  logic        Redirect,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IMemReady,
    input  logic        DMemReady,
    output logic [31:0] NextAddress,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        WaitTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_q;
    logic             load_use;
    logic             mem_busy;

    load_use_detect u_load_use (
        .idex_mem_read (IDEX_MemRead),
        .idex_rt       (IDEX_Rt),
        .ifid_rs       (IFID_Rs),
        .ifid_rt       (IFID_Rt),
        .load_use      (load_use)
    );

    assign mem_busy = !IMemReady || !DMemReady;
    assign cnt_inc  = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= RUN;
            hold_q    <= RESET_VECTOR;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q || (cnt_d == CNT_LIMIT);
        end
    end

    // Mealy next-state and control outputs.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        NextAddress = PCPlus4;
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;

        case (state_q)
            RUN, MEMWAIT: begin
                if (mem_busy) begin
                    cnt_d = (state_q == RUN) ? CNT_ONE : cnt_inc;
                    if (Redirect && !load_use) begin
                        hold_d  = BranchTarget;
                        state_d = REDIRPEND;
                    end else begin
                        state_d = MEMWAIT;
                    end
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (load_use) begin
                        // Branch operands are not valid yet, so a redirect waits.
                        IDEXBubble = 1'b1;
                    end else if (Redirect) begin
                        NextAddress = BranchTarget;
                        PCWrite     = 1'b1;
                        IFIDWrite   = 1'b1;
                        IFIDFlush   = 1'b1;
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDWrite = 1'b1;
                    end
                end
            end
            REDIRPEND: begin
                if (mem_busy) begin
                    cnt_d = cnt_inc;
                end else begin
                    NextAddress = hold_q;
                    PCWrite     = 1'b1;
                    IFIDWrite   = 1'b1;
                    IFIDFlush   = 1'b1;
                    state_d     = RUN;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (!Reset) begin
            NextAddress = RESET_VECTOR;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
        end
    end

    assign WaitTimeout = timeout_q;

`ifdef PC_SEQ_STATS_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PCWrite)  stall_q <= stall_q + 32'd1;
            if (IFIDFlush) flush_q <= flush_q + 32'd1;
        end
    end

    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule
